// File: rtl/iis_pkg.sv
// Shared definitions for the IIS receiver and transmitter: FSM state
// encodings, channel codes and control-word bit positions.
package iis_pkg;

   // Receiver state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Channel codes, matching the ws level
   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   // Bit positions in the recv_ctrl / send_ctrl words
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MONO = 1;
   localparam int CTRL_CLR  = 2;

endpackage

// File: rtl/iis_ws_edge.sv
// Word-select edge detector: registers ws on the bit clock and flags any
// cycle in which ws differs from its registered copy.
module iis_ws_edge (
   input  logic sck,
   input  logic rst,
   input  logic ws,
   output logic ws_d,
   output logic ws_edge
);

   // Register ws once per bit clock
   always_ff @(posedge sck or negedge rst) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst) ws_d <= 1'b0;
      else      ws_d <= ws;
   end

   assign ws_edge = ws ^ ws_d;

endmodule

// File: rtl/iis_receive.sv
// I2S receiver: captures MSB-first words from an external master on sck,
// writes them to the RX FIFO and tracks word count and error flags.
module iis_receive
   import iis_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_DEPTH = 64
) (
   input  logic                  sck,
   input  logic                  rst,
   input  logic                  sd,
   input  logic                  ws,
   input  logic [2:0]            recv_ctrl,
   input  logic                  fifo_full,
   output logic                  wr_clk,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data,
   output logic                  channel,
   output logic [31:0]           recv_num,
   output logic                  recv_finish,
   output logic                  overflow,
   output logic                  frame_err
);

   localparam int                CNT_W      = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
   localparam logic [31:0]       FINISH_NUM = 32'(DATA_DEPTH - 1);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] next_word;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  chan;
   logic                  ws_d;
   logic                  ws_edge;
   logic                  enable;
   logic                  mono;
   logic                  clear;
   logic                  word_done;
   logic                  write_go;
   logic                  drop_full;
   logic                  short_slot;

   assign enable = recv_ctrl[CTRL_EN];
   assign mono   = recv_ctrl[CTRL_MONO];
   assign clear  = recv_ctrl[CTRL_CLR];

   // The FIFO is written in the bit-clock domain
   assign wr_clk = sck;

   iis_ws_edge u_ws_edge (
      .sck     (sck),
      .rst     (rst),
      .ws      (ws),
      .ws_d    (ws_d),
      .ws_edge (ws_edge)
   );

   // The word as it stands once the current sd bit is shifted in
   assign next_word = {shift_reg[DATA_WIDTH-2:0], sd};

   assign recv_finish = (recv_num == FINISH_NUM);

   // Decode word completion, slot truncation and the write/drop decision
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      word_done  = 1'b0;
      short_slot = 1'b0;
      write_go   = 1'b0;
      drop_full  = 1'b0;
      if (enable && state == ST_SHIFT) begin
         if (ws_edge)                  short_slot = 1'b1;
         else if (bit_cnt == LAST_BIT) word_done  = 1'b1;
      end
      if (word_done && !(mono && chan == CH_RIGHT)) begin
         if (fifo_full) drop_full = 1'b1;
         else           write_go  = 1'b1;
      end
   end

   // Slot FSM, deserialiser and registered FIFO write port
   always_ff @(posedge sck or negedge rst) begin
      // NOTE: shift_reg and the write data port are plain registers, so they
      // take an async reset like the control state.
      if (!rst) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         chan         <= CH_LEFT;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         channel      <= CH_LEFT;
      end else begin
         fifo_wr_en <= 1'b0;
         if (!enable) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_SYNC;
               ST_SYNC, ST_HOLD: begin
                  if (ws_edge) begin
                     // On an edge ws is the complement of its registered copy
                     state     <= ST_SHIFT;
                     chan      <= ~ws_d;
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end
               end
               default: begin
                  if (ws_edge) begin
                     // Truncated slot: drop the partial word, restart on new channel
                     chan      <= ~ws_d;
                     bit_cnt   <= '0;
                     shift_reg <= '0;
                  end else begin
                     shift_reg <= next_word;
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) state <= ST_HOLD;
                  end
               end
            endcase
         end
         if (write_go) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= next_word;
            channel      <= chan;
         end
      end
   end

   // Word counter and sticky status flags; clear wins over any update
   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         recv_num  <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else if (clear) begin
         recv_num  <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (write_go)   recv_num  <= recv_finish ? '0 : recv_num + 32'd1;
         if (drop_full)  overflow  <= 1'b1;
         if (short_slot) frame_err <= 1'b1;
      end
   end

endmodule
